// File: rtl/misc_decoder_pkg.sv
// Shared constants, record layout helpers and receiver state type for the
// misc sideband decoder.
package misc_decoder_pkg;

  // Record layout
  localparam int REC_W          = 64;
  localparam int REC_SRC        = 63;
  localparam int REC_ERR        = 62;

  // Reflect channel
  localparam int REFL_LEN       = 40;

  // UART channel
  localparam int UART_BYTES     = 5;
  localparam int UART_PAYLOAD   = 7;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_PAYLOAD_W = UART_BYTES * UART_PAYLOAD;

  // Output buffering
  localparam int FIFO_DEPTH     = 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  // Reflect record: source 0, no error, count in the low bits.
  function automatic logic [REC_W-1:0] refl_record(input logic [REFL_LEN-1:0] cnt);
    logic [REC_W-1:0] rec;
    rec = '0;
    rec[REFL_LEN-1:0] = cnt;
    return rec;
  endfunction

  // UART record: source 1, payload placed at [38:4], bit 39 and [3:0] zero.
  function automatic logic [REC_W-1:0] uart_record(input logic [UART_PAYLOAD_W-1:0] payload);
    logic [REC_W-1:0] rec;
    rec = '0;
    rec[REC_SRC] = 1'b1;
    rec[UART_PAYLOAD_W+3:4] = payload;
    return rec;
  endfunction

  // UART framing error record: source 1, error 1, everything else zero.
  function automatic logic [REC_W-1:0] err_record();
    logic [REC_W-1:0] rec;
    rec = '0;
    rec[REC_SRC] = 1'b1;
    rec[REC_ERR] = 1'b1;
    return rec;
  endfunction

endpackage

// File: rtl/misc_uart_rx.sv
// Oversampled UART byte receiver for the slow misc channel. Only samples with
// sample_en high advance it; byte_valid / frame_err are single-sample pulses
// produced combinationally on the sample that carries the stop bit.
module misc_uart_rx
  import misc_decoder_pkg::*;
#(
  parameter int BIT_PERIOD = 63
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      sample_en,
  input  logic                      line,
  output logic                      byte_valid,
  output logic [UART_DATA_BITS-1:0] byte_data,
  output logic                      frame_err
);

  localparam int CNT_W = $clog2(BIT_PERIOD + 1);
  // Mid-bit offset from the falling start edge, and the full bit spacing.
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((BIT_PERIOD - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BIT_PERIOD);

  rx_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          cnt_inc;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      prev_q, prev_d;

  assign cnt_inc   = cnt_q + 1'b1;
  assign byte_data = shift_q;

  // Next-state logic: edge detect, mid-bit sampling and stop-bit verdict.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    prev_d     = prev_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (sample_en) begin
      prev_d = line;
      case (state_q)
        IDLE: begin
          // A start bit is a high-to-low transition between accepted samples.
          if (prev_q && !line) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_inc == HALF_CNT) begin
            cnt_d = '0;
            bit_d = '0;
            // Line went back high before mid-bit: treat as a glitch.
            state_d = line ? IDLE : DATA;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        DATA: begin
          if (cnt_inc == FULL_CNT) begin
            cnt_d   = '0;
            shift_d = {line, shift_q[UART_DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == 3'(UART_DATA_BITS - 1)) begin
              state_d = STOP;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        STOP: begin
          if (cnt_inc == FULL_CNT) begin
            cnt_d      = '0;
            state_d    = IDLE;
            byte_valid = line;
            frame_err  = !line;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; prev starts low so a line that is low out of reset
  // cannot fake a start edge.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      prev_q  <= prev_d;
    end
  end

endmodule

// File: rtl/axis_misc_decoder.sv
// Misc sideband decoder: recovers pulse-counter metadata from the reflect and
// UART channels carried in the top bits of each sample and emits one 64-bit
// record per decoded frame through a 2-entry output FIFO.
module axis_misc_decoder
  import misc_decoder_pkg::*;
#(
  parameter int S_AXIS_TDATA_WIDTH = 40,
  parameter int MISC_WIDTH         = 8,
  parameter int UART_BIT           = 0,
  parameter int REFL_BIT           = 1,
  parameter int FLAG_BIT           = 2,
  parameter int BIT_PERIOD         = 63
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [REC_W-1:0]              m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          overflow
);

  localparam int MISC_LSB = S_AXIS_TDATA_WIDTH - MISC_WIDTH;
  localparam int POS_W    = $clog2(REFL_LEN);

  // ---------------------------------------------------------------- input
  logic tready_q;
  logic accept;
  logic misc_uart;
  logic misc_refl;
  logic misc_flag;
  logic tdata_unused;

  assign s_axis_tready = tready_q;
  assign accept        = s_axis_tvalid & tready_q;
  assign misc_uart     = s_axis_tdata[MISC_LSB + UART_BIT];
  assign misc_refl     = s_axis_tdata[MISC_LSB + REFL_BIT];
  assign misc_flag     = s_axis_tdata[MISC_LSB + FLAG_BIT];
  // Sample payload and spare misc bits are not decoded here.
  assign tdata_unused  = ^s_axis_tdata;

  // ------------------------------------------------------ reflect decoder
  logic [REFL_LEN-1:0] refl_data_q, refl_data_d;
  logic [POS_W-1:0]    refl_pos_q, refl_pos_d;
  logic                refl_armed_q, refl_armed_d;
  logic                refl_done;
  logic [REC_W-1:0]    refl_rec;

  // Reflect framing: flag-low (re)captures bit0, flag-high fills the rest.
  always_comb begin
    refl_data_d  = refl_data_q;
    refl_pos_d   = refl_pos_q;
    refl_armed_d = refl_armed_q;
    refl_done    = 1'b0;
    if (accept) begin
      if (!misc_flag) begin
        refl_data_d    = '0;
        refl_data_d[0] = misc_refl;
        refl_pos_d     = POS_W'(1);
        refl_armed_d   = 1'b1;
      end else if (refl_armed_q) begin
        refl_data_d[refl_pos_q] = misc_refl;
        refl_pos_d              = refl_pos_q + 1'b1;
        if (refl_pos_q == POS_W'(REFL_LEN - 1)) begin
          refl_done    = 1'b1;
          refl_armed_d = 1'b0;
        end
      end
    end
  end

  assign refl_rec = refl_record(refl_data_d);

  // ------------------------------------------------------ UART receiver
  logic                      rx_valid;
  logic [UART_DATA_BITS-1:0] rx_byte;
  logic                      rx_err;

  misc_uart_rx #(
    .BIT_PERIOD (BIT_PERIOD)
  ) u_uart_rx (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .sample_en  (accept),
    .line       (misc_uart),
    .byte_valid (rx_valid),
    .byte_data  (rx_byte),
    .frame_err  (rx_err)
  );

  // ------------------------------------------------ UART frame assembler
  logic [UART_PAYLOAD_W-1:0] pay_q, pay_d;
  logic [2:0]                idx_q, idx_d;
  logic                      uart_done;
  logic                      uart_err;
  logic                      uart_push;
  logic [REC_W-1:0]          uart_rec;

  // Byte assembly: d[7] opens a frame, four continuation bytes complete it.
  always_comb begin
    pay_d     = pay_q;
    idx_d     = idx_q;
    uart_done = 1'b0;
    uart_err  = 1'b0;
    if (rx_err) begin
      idx_d    = '0;
      uart_err = 1'b1;
    end else if (rx_valid) begin
      if (rx_byte[UART_DATA_BITS-1]) begin
        pay_d                   = '0;
        pay_d[UART_PAYLOAD-1:0] = rx_byte[UART_PAYLOAD-1:0];
        idx_d                   = 3'd1;
      end else if (idx_q != 3'd0) begin
        pay_d[idx_q*UART_PAYLOAD +: UART_PAYLOAD] = rx_byte[UART_PAYLOAD-1:0];
        if (idx_q == 3'(UART_BYTES - 1)) begin
          uart_done = 1'b1;
          idx_d     = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      // Continuation byte with no open frame is ignored.
    end
  end

  assign uart_push = uart_done | uart_err;
  assign uart_rec  = uart_err ? err_record() : uart_record(pay_d);

  // ------------------------------------------------------- output FIFO
  logic [REC_W-1:0] fifo_q [FIFO_DEPTH];
  logic [REC_W-1:0] fifo_d [FIFO_DEPTH];
  logic [1:0]       count_q, count_d;
  logic [1:0]       fifo_fill;
  logic             ovf_q, ovf_d;
  logic             pop;

  assign pop           = (count_q != 2'd0) && m_axis_tready;
  assign m_axis_tdata  = fifo_q[0];
  assign m_axis_tvalid = (count_q != 2'd0);
  assign overflow      = ovf_q;

  // Pop first so its slot is reusable, then append reflect before UART.
  always_comb begin
    fifo_d[0] = pop ? fifo_q[1] : fifo_q[0];
    fifo_d[1] = fifo_q[1];
    fifo_fill = count_q - {1'b0, pop};
    ovf_d     = ovf_q;
    if (refl_done) begin
      if (fifo_fill != 2'(FIFO_DEPTH)) begin
        fifo_d[fifo_fill[0]] = refl_rec;
        fifo_fill            = fifo_fill + 2'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (uart_push) begin
      if (fifo_fill != 2'(FIFO_DEPTH)) begin
        fifo_d[fifo_fill[0]] = uart_rec;
        fifo_fill            = fifo_fill + 2'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end
    count_d = fifo_fill;
  end

  // All decoder, assembler and FIFO state; reset drops any partial frame.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tready_q     <= 1'b0;
      refl_data_q  <= '0;
      refl_pos_q   <= '0;
      refl_armed_q <= 1'b0;
      pay_q        <= '0;
      idx_q        <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      tready_q     <= 1'b1;
      refl_data_q  <= refl_data_d;
      refl_pos_q   <= refl_pos_d;
      refl_armed_q <= refl_armed_d;
      pay_q        <= pay_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

endmodule

// File: tb/tb_axis_misc_decoder.sv
// Bench for axis_misc_decoder. Stimulus is laid out as per-sample arrays for
// the UART line and the reflect flag/data; the builders that write a frame
// also note which sample completes it and the record that sample must yield.
// A queue models the 2-entry output FIFO and is compared every cycle.
module tb_axis_misc_decoder;

  localparam int W        = 40;
  localparam int BP       = 63;
  localparam int MID      = (BP - 1) / 2;
  localparam int BYTE_LEN = 11 * BP;
  localparam int NS       = 32768;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [63:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          overflow;

  always #5 aclk = ~aclk;

  axis_misc_decoder #(
    .S_AXIS_TDATA_WIDTH (W),
    .MISC_WIDTH         (8),
    .UART_BIT           (0),
    .REFL_BIT           (1),
    .FLAG_BIT           (2),
    .BIT_PERIOD         (BP)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .overflow      (overflow)
  );

  // Per-sample stimulus and expected completions
  logic        line_a [NS];
  logic        flag_a [NS];
  logic        refl_a [NS];
  bit          exp_rv [NS];
  bit          exp_uv [NS];
  logic [63:0] exp_r  [NS];
  logic [63:0] exp_u  [NS];

  logic [63:0] mq [$];
  logic        ovf_m;
  int          sidx;
  int          wpos;
  int          n_checks;
  int          n_pass;
  int          n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("tvalid", {63'd0, m_axis_tvalid}, {63'd0, mq.size() != 0});
    if (mq.size() != 0) chk("tdata", m_axis_tdata, mq[0]);
    chk("overflow", {63'd0, overflow}, {63'd0, ovf_m});
    chk("s_tready", {63'd0, s_axis_tready}, 64'd1);
  endtask

  task automatic push_rec(input logic [63:0] rec);
    if (mq.size() < 2) mq.push_back(rec);
    else ovf_m = 1'b1;
  endtask

  // One clock: update the FIFO model at the edge, compare at the falling edge.
  task automatic tick();
    bit acc;
    acc = s_axis_tvalid;
    @(posedge aclk);
    if (mq.size() != 0 && m_axis_tready) void'(mq.pop_front());
    if (acc) begin
      if (exp_rv[sidx]) push_rec(exp_r[sidx]);
      if (exp_uv[sidx]) push_rec(exp_u[sidx]);
    end
    @(negedge aclk);
    check_outputs();
  endtask

  function automatic logic [W-1:0] make_sample(input int i);
    logic [7:0] misc;
    misc    = 8'($urandom);
    misc[0] = line_a[i];
    misc[1] = refl_a[i];
    misc[2] = flag_a[i];
    return {misc, 32'($urandom)};
  endfunction

  // Present samples up to (not including) stop_idx, with idle gaps and
  // random output backpressure.
  task automatic run_to(input int stop_idx, input int gap_pct, input int rdy_pct);
    while (sidx < stop_idx) begin
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = W'({$urandom, $urandom});
      end else begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = make_sample(sidx);
      end
      m_axis_tready = (int'($urandom_range(0, 99)) < rdy_pct);
      tick();
      if (s_axis_tvalid) sidx++;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'($urandom);
    repeat (cycles) begin
      @(posedge aclk);
      @(negedge aclk);
      chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
      chk("rst_tdata", m_axis_tdata, 64'd0);
      chk("rst_overflow", {63'd0, overflow}, 64'd0);
      chk("rst_s_tready", {63'd0, s_axis_tready}, 64'd0);
    end
    mq.delete();
    ovf_m   = 1'b0;
    aresetn = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check_outputs();
  endtask

  // Reflect frame: pre extra flag-low samples (random bit, superseded),
  // then bit0 with flag low, bits 1..39 with flag high, then rep repeats of bit39.
  task automatic refl_frame(input int at, input logic [39:0] c, input int pre, input int rep);
    for (int i = 0; i < pre; i++) begin
      flag_a[at+i] = 1'b0;
      refl_a[at+i] = 1'($urandom);
    end
    flag_a[at+pre] = 1'b0;
    refl_a[at+pre] = c[0];
    for (int b = 1; b < 40; b++) begin
      flag_a[at+pre+b] = 1'b1;
      refl_a[at+pre+b] = c[b];
    end
    for (int r = 0; r < rep; r++) begin
      flag_a[at+pre+40+r] = 1'b1;
      refl_a[at+pre+40+r] = c[39];
    end
    exp_rv[at+pre+39] = 1'b1;
    exp_r[at+pre+39]  = {24'h0, c};
  endtask

  // 11 slots of BP samples: start, 8 data LSB first, stop, pad.
  task automatic uart_byte(input int at, input logic [7:0] b, input logic stop_bit);
    logic v;
    for (int s = 0; s < 11; s++) begin
      if (s == 0) v = 1'b0;
      else if (s <= 8) v = b[s-1];
      else if (s == 9) v = stop_bit;
      else v = 1'b1;
      for (int j = 0; j < BP; j++) line_a[at + s*BP + j] = v;
    end
  endtask

  function automatic int stop_idx(input int byte_at);
    return byte_at + 9*BP + MID;
  endfunction

  // Five bytes back to back; record due on the last stop-bit sample.
  task automatic uart_frame(input int at, input logic [39:0] bytes);
    logic [34:0] p;
    int          t;
    for (int k = 0; k < 5; k++) begin
      uart_byte(at + k*BYTE_LEN, bytes[8*k +: 8], 1'b1);
      p[7*k +: 7] = bytes[8*k +: 7];
    end
    t         = stop_idx(at + 4*BYTE_LEN);
    exp_uv[t] = 1'b1;
    exp_u[t]  = {1'b1, 1'b0, 22'h0, 1'b0, p, 4'h0};
  endtask

  function automatic logic [39:0] rand_frame();
    logic [39:0] f;
    for (int k = 0; k < 5; k++) f[8*k +: 8] = {1'b0, 7'($urandom)};
    f[7] = 1'b1;
    return f;
  endfunction

  function automatic logic [39:0] rand40();
    return 40'({$urandom, $urandom});
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: observed no finish, expected finish before 5ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    int t;
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    ovf_m    = 1'b0;
    sidx     = 0;
    wpos     = 0;
    for (int i = 0; i < NS; i++) begin
      line_a[i] = 1'b1;
      flag_a[i] = 1'b1;
      refl_a[i] = 1'b0;
      exp_rv[i] = 1'b0;
      exp_uv[i] = 1'b0;
      exp_r[i]  = '0;
      exp_u[i]  = '0;
    end

    // Reset state
    do_reset(2);

    // Reflect frame 0x1235 followed by 100 saturated repeats of bit39
    wpos += 5;
    refl_frame(wpos, 40'h00_0000_1235, 2, 100);
    wpos += 2 + 40 + 100 + 5;
    run_to(wpos, 0, 100);

    // UART frame 0x81,0x02,0x03,0x04,0x05
    wpos += 5;
    uart_frame(wpos, {8'h05, 8'h04, 8'h03, 8'h02, 8'h81});
    wpos += 5*BYTE_LEN + 5;
    run_to(wpos, 0, 100);

    // 10-sample glitch, then a frame broken by a bad stop bit, a stray
    // continuation byte, then a good frame
    for (int i = 0; i < 10; i++) line_a[wpos + 5 + i] = 1'b0;
    wpos += 45;
    uart_byte(wpos, 8'h81, 1'b1);
    uart_byte(wpos + BYTE_LEN, 8'h02, 1'b1);
    uart_byte(wpos + 2*BYTE_LEN, 8'h03, 1'b0);
    t         = stop_idx(wpos + 2*BYTE_LEN);
    exp_uv[t] = 1'b1;
    exp_u[t]  = {2'b11, 62'h0};
    wpos += 3*BYTE_LEN + 5;
    uart_byte(wpos, 8'h33, 1'b1);
    wpos += BYTE_LEN + 5;
    uart_frame(wpos, rand_frame());
    wpos += 5*BYTE_LEN + 5;
    run_to(wpos, 0, 100);

    // Reflect and UART complete on the same sample with the sink stalled,
    // then a third frame overflows
    wpos += 5;
    a = wpos;
    uart_frame(a, rand_frame());
    t = stop_idx(a + 4*BYTE_LEN);
    refl_frame(t - 39, rand40(), 0, 0);
    wpos = a + 5*BYTE_LEN + 5;
    refl_frame(wpos, rand40(), 0, 3);
    wpos += 50;
    run_to(wpos, 10, 0);
    wpos += 10;
    run_to(wpos, 0, 100);

    // Input gaps and random backpressure
    wpos += 5;
    uart_frame(wpos, rand_frame());
    wpos += 5*BYTE_LEN + 5;
    refl_frame(wpos, rand40(), 1, 4);
    wpos += 50;
    run_to(wpos, 40, 50);
    wpos += 10;
    run_to(wpos, 0, 100);

    // Reset with the reflect decoder at pos 20
    wpos += 5;
    a = wpos;
    refl_frame(a, rand40(), 0, 0);
    run_to(a + 20, 0, 100);
    do_reset(2);
    sidx = a + 45;
    wpos = sidx;

    // Reset part-way through the third UART byte
    wpos += 5;
    a = wpos;
    uart_frame(a, rand_frame());
    run_to(a + 2*BYTE_LEN + 300, 20, 100);
    do_reset(2);
    sidx = a + 5*BYTE_LEN + 5;
    wpos = sidx;

    // Complete frames decode after reset
    wpos += 5;
    refl_frame(wpos, rand40(), 1, 5);
    wpos += 50;
    uart_frame(wpos, rand_frame());
    wpos += 5*BYTE_LEN + 5;
    run_to(wpos, 25, 70);
    wpos += 10;
    run_to(wpos, 0, 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
